// File: rtl/regfile_param.sv
// Parametrised integer register file with two read ports, one write port and a clear sequencer.
// The sequencer zeroes one entry per cycle after reset or on request, and holds busy high while it runs.
module regfile_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  input  logic            Wen,
  input  logic [AW-1:0]   addr_D,
  input  logic [XLEN-1:0] data_D,
  input  logic [AW-1:0]   addr_A,
  input  logic [AW-1:0]   addr_B,
  output logic [XLEN-1:0] data_A,
  output logic [XLEN-1:0] data_B,
  output logic            busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   clr_cnt, clr_cnt_next;
  logic [XLEN-1:0] mem [NREGS];
  logic            wr_en;
  logic [XLEN-1:0] sel_a, sel_b;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt == AW'(NREGS - 1)) begin
          state_next   = IDLE;
          clr_cnt_next = '0;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_next   = CLEAR;
        clr_cnt_next = '0;
      end
    endcase
  end

  assign busy  = (state == CLEAR);
  assign wr_en = !busy && Wen && !((ZERO_REG != 0) && (addr_D == '0));

  // NOTE: the array has no reset branch; the clear sequencer zeroes it, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[addr_D] <= data_D;
    end
  end

  // Priority: clearing, then hardwired zero, then write-first bypass, then stored value.
  always_comb begin
    sel_a = mem[addr_A];
    if (busy || ((ZERO_REG != 0) && (addr_A == '0))) begin
      sel_a = '0;
    end else if ((BYPASS != 0) && Wen && (addr_D == addr_A)) begin
      sel_a = data_D;
    end
  end

  always_comb begin
    sel_b = mem[addr_B];
    if (busy || ((ZERO_REG != 0) && (addr_B == '0))) begin
      sel_b = '0;
    end else if ((BYPASS != 0) && Wen && (addr_D == addr_B)) begin
      sel_b = data_D;
    end
  end

  if (READ_LAT != 0) begin : g_reg_read
    logic [XLEN-1:0] q_a, q_b;

    always_ff @(posedge clk) begin
      if (rst) begin
        q_a <= '0;
        q_b <= '0;
      end else begin
        q_a <= sel_a;
        q_b <= sel_b;
      end
    end

    assign data_A = q_a;
    assign data_B = q_b;
  end else begin : g_comb_read
    assign data_A = sel_a;
    assign data_B = sel_b;
  end

endmodule
